// File: rtl/activation_inverse_if.sv
// ---------------------------------------------------------------------------
// activation_inverse_if
//
// Bundles the table-write port, the request handshake and the response
// handshake of activation_inverse.
//
//   wr_en / wr_addr / wr_data   table write strobe, entry index 0..16, value
//   req_valid / req_ready       request handshake, a_value is the operand
//   rsp_valid / rsp_ready       response handshake
//   z_value                     recovered pre-activation value (signed)
//   rsp_clamp                   operand fell outside the table range
//
// Modports:
//   master - the side issuing requests and table writes
//   slave  - the activation_inverse block
// ---------------------------------------------------------------------------
interface activation_inverse_if;
    logic              wr_en;
    logic [4:0]        wr_addr;
    logic signed [7:0] wr_data;

    logic              req_valid;
    logic              req_ready;
    logic signed [7:0] a_value;

    logic              rsp_valid;
    logic              rsp_ready;
    logic signed [7:0] z_value;
    logic              rsp_clamp;

    modport master (
        output wr_en, wr_addr, wr_data,
        output req_valid, a_value,
        output rsp_ready,
        input  req_ready, rsp_valid, z_value, rsp_clamp
    );

    modport slave (
        input  wr_en, wr_addr, wr_data,
        input  req_valid, a_value,
        input  rsp_ready,
        output req_ready, rsp_valid, z_value, rsp_clamp
    );
endinterface

// File: rtl/activation_inverse.sv
// ---------------------------------------------------------------------------
// activation_inverse
//
// Inverts a monotonic activation function given as a 17-point piecewise-
// linear table. Entry T[s] is the activation at z = s*16-128 (s = 0..15),
// T[16] is the activation at z = +127. For an activation value a the block
// finds the segment s with T[s] <= a < T[s+1] by a 4-step binary search,
// then interpolates the 4-bit fraction inside the segment with a 4-step
// restoring divider. Operands outside [T[0], T[16]) saturate to -128/+127
// and raise rsp_clamp.
//
// Ports:
//   clk  - single clock, rising edge
//   rst  - asynchronous, active-low reset (aborts any operation and
//          restores the identity table)
//   bus  - activation_inverse_if.slave (table writes, request, response)
//
// Timing (edges counted from the accept edge):
//   normal path : 1 range check + 4 search + 4 divide -> rsp_valid at 9
//   clamp path  : 1 range check + 1 hand-off          -> rsp_valid at 2
// ---------------------------------------------------------------------------
module activation_inverse (
    input  logic                  clk,
    input  logic                  rst,
    activation_inverse_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEARCH  = 2'd1,
        DIVIDE  = 2'd2,
        RESPOND = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;

    // Breakpoint table and working registers.
    logic signed [7:0] tbl [0:16];
    logic signed [7:0] a_reg;
    logic [3:0]        s_idx;
    logic [3:0]        quot;
    logic [9:0]        rem;
    logic [2:0]        step;
    logic              clamp_hit;
    logic signed [7:0] z_reg;
    logic              clamp_reg;

    // Segment index and 4-bit fraction map onto z = s*16 - 128 + frac.
    // s*16 + frac is simply {s, frac}; subtracting 128 flips its MSB.
    function automatic logic signed [7:0] seg_to_z(input logic [3:0] seg,
                                                   input logic [3:0] frac);
        return $signed({~seg[3], seg[2:0], frac});
    endfunction

    // ---------------------------------------------------------------------
    // Search datapath
    // ---------------------------------------------------------------------
    logic [1:0]        bit_idx;
    logic [3:0]        trial;
    logic signed [7:0] t_trial;
    logic              trial_hit;
    logic [3:0]        s_srch;
    logic signed [7:0] t_first;
    logic signed [7:0] t_last;
    logic              below_range;
    logic              above_range;
    logic signed [7:0] t_seg;
    logic signed [8:0] num_diff;

    always_comb begin
        // Search step 1..4 tests bit 3..0 of the segment index.
        bit_idx     = 2'(3'd4 - step);
        trial       = s_idx | (4'd1 << bit_idx);
        t_trial     = tbl[{1'b0, trial}];
        trial_hit   = (t_trial <= a_reg);
        s_srch      = trial_hit ? trial : s_idx;

        t_first     = tbl[0];
        t_last      = tbl[16];
        below_range = (a_reg < t_first);
        above_range = (a_reg >= t_last);

        // Numerator seeded from the segment the final search step settles on.
        t_seg       = tbl[{1'b0, s_srch}];
        num_diff    = {a_reg[7], a_reg} - {t_seg[7], t_seg};
    end

    // ---------------------------------------------------------------------
    // Divide datapath
    // ---------------------------------------------------------------------
    logic [4:0]        idx_hi;
    logic signed [7:0] t_lo;
    logic signed [7:0] t_hi;
    logic signed [8:0] den_diff;
    logic [9:0]        den_ext;
    logic [9:0]        rem_sh;
    logic              qbit;
    logic [9:0]        rem_nxt;
    logic [3:0]        quot_nxt;

    always_comb begin
        idx_hi   = {1'b0, s_idx} + 5'd1;
        t_lo     = tbl[{1'b0, s_idx}];
        t_hi     = tbl[idx_hi];
        // Non-negative for a monotonic table; at least 1 whenever the
        // operand lies strictly inside the table range.
        den_diff = {t_hi[7], t_hi} - {t_lo[7], t_lo};
        den_ext  = {1'b0, den_diff};

        // Remainder stays below the denominator (< 256), so the shifted
        // value fits 10 bits.
        rem_sh   = rem << 1;
        qbit     = (rem_sh >= den_ext);
        rem_nxt  = qbit ? (rem_sh - den_ext) : rem_sh;
        quot_nxt = {quot[2:0], qbit};
    end

    // ---------------------------------------------------------------------
    // FSM state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------------------------------------------------------------
    // FSM next state and handshake outputs
    // ---------------------------------------------------------------------
    always_comb begin
        state_nxt     = state;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;

        unique case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    state_nxt = SEARCH;
                end
            end

            SEARCH: begin
                // Step 0 is the range check. A clamped operand spends one
                // more cycle here before the response is presented.
                if (step != 3'd0) begin
                    if (clamp_hit) begin
                        state_nxt = RESPOND;
                    end else if (step == 3'd4) begin
                        state_nxt = DIVIDE;
                    end
                end
            end

            DIVIDE: begin
                if (step == 3'd3) begin
                    state_nxt = RESPOND;
                end
            end

            RESPOND: begin
                bus.rsp_valid = 1'b1;
                // Returning to IDLE first keeps a new request from being
                // accepted on the same edge that consumes this response.
                if (bus.rsp_ready) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Table and datapath registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // Identity table: T[s] = s*16-128, T[16] = 127.
            for (int i = 0; i < 16; i++) begin
                tbl[i] <= 8'(i * 16 - 128);
            end
            tbl[16]   <= 8'sh7F;
            a_reg     <= '0;
            s_idx     <= '0;
            quot      <= '0;
            rem       <= '0;
            step      <= '0;
            clamp_hit <= 1'b0;
            z_reg     <= '0;
            clamp_reg <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.wr_en && (bus.wr_addr <= 5'd16)) begin
                        tbl[bus.wr_addr] <= bus.wr_data;
                    end
                    if (bus.req_valid) begin
                        a_reg     <= bus.a_value;
                        s_idx     <= '0;
                        quot      <= '0;
                        step      <= '0;
                        clamp_hit <= 1'b0;
                    end
                end

                SEARCH: begin
                    if (step == 3'd0) begin
                        if (below_range) begin
                            z_reg     <= 8'sh80;
                            clamp_reg <= 1'b1;
                            clamp_hit <= 1'b1;
                        end else if (above_range) begin
                            z_reg     <= 8'sh7F;
                            clamp_reg <= 1'b1;
                            clamp_hit <= 1'b1;
                        end
                        step <= 3'd1;
                    end else if (!clamp_hit) begin
                        s_idx <= s_srch;
                        if (step == 3'd4) begin
                            rem  <= {1'b0, num_diff};
                            step <= '0;
                        end else begin
                            step <= step + 3'd1;
                        end
                    end
                end

                DIVIDE: begin
                    rem  <= rem_nxt;
                    quot <= quot_nxt;
                    if (step == 3'd3) begin
                        z_reg     <= seg_to_z(s_idx, quot_nxt);
                        clamp_reg <= 1'b0;
                        step      <= '0;
                    end else begin
                        step <= step + 3'd1;
                    end
                end

                RESPOND: begin
                    // Result registers hold until the response is consumed.
                end

                default: begin
                end
            endcase
        end
    end

    assign bus.z_value   = z_reg;
    assign bus.rsp_clamp = clamp_reg;

endmodule

// File: tb/tb_activation_inverse.sv
// ---------------------------------------------------------------------------
// tb_activation_inverse
//
// Directed scenarios plus randomized requests against monotonic random
// tables, each checked against a behavioural model: linear segment scan,
// integer interpolation, fixed latencies of 9 (normal) or 2 (clamped).
// ---------------------------------------------------------------------------
module tb_activation_inverse;

    logic clk;
    logic rst;

    activation_inverse_if bus ();

    activation_inverse dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_errors;
    int mt [0:16];

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_identity();
        for (int i = 0; i < 16; i++) mt[i] = i * 16 - 128;
        mt[16] = 127;
    endfunction

    // Expected result straight from the segment definition.
    function automatic void ref_inv(input int a, output int z, output int c,
                                    output int l);
        int s;
        int frac;
        if (a < mt[0]) begin
            z = -128; c = 1; l = 2;
        end else if (a >= mt[16]) begin
            z = 127; c = 1; l = 2;
        end else begin
            s = 0;
            for (int i = 0; i < 16; i++) if (mt[i] <= a) s = i;
            frac = ((a - mt[s]) * 16) / (mt[s + 1] - mt[s]);
            z = s * 16 - 128 + frac;
            c = 0; l = 9;
        end
    endfunction

    task automatic tb_write(input int addr, input int data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 5'(addr);
        bus.wr_data = 8'(data);
        @(posedge clk); #1;
        bus.wr_en   = 1'b0;
        if (addr <= 16) mt[addr] = data;
    endtask

    task automatic run_req(input int a, input int hold, input bit inj);
        int ez, ec, el, lat, w;
        ref_inv(a, ez, ec, el);
        w = 0;
        while (!bus.req_ready && w < 50) begin
            @(posedge clk); #1; w++;
        end
        check_val("req_ready_before_req", int'(bus.req_ready), 1);
        bus.req_valid = 1'b1;
        bus.a_value   = 8'(a);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.a_value   = 8'($urandom);
        if (inj) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = 5'd10;
            bus.wr_data = 8'sd0;
        end
        lat = 0;
        while (!bus.rsp_valid && lat < 30) begin
            @(posedge clk); #1; lat++;
            if (lat == 2) bus.wr_en = 1'b0;
        end
        bus.wr_en = 1'b0;
        check_val("latency", lat, el);
        check_val("z_value", int'(bus.z_value), ez);
        check_val("rsp_clamp", int'(bus.rsp_clamp), ec);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check_val("hold_rsp_valid", int'(bus.rsp_valid), 1);
            check_val("hold_req_ready", int'(bus.req_ready), 0);
            check_val("hold_z_value", int'(bus.z_value), ez);
            check_val("hold_rsp_clamp", int'(bus.rsp_clamp), ec);
        end
        // Consume while also offering a new request: it must not be taken.
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1;
        bus.a_value   = 8'($urandom);
        @(posedge clk); #1;
        check_val("idle_after_consume", int'(bus.req_ready), 1);
        check_val("rsp_valid_after_consume", int'(bus.rsp_valid), 0);
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b0;
    endtask

    task automatic random_table();
        int v;
        v = -128 + int'($urandom_range(0, 30));
        for (int i = 0; i <= 16; i++) begin
            tb_write(i, v);
            v = v + int'($urandom_range(0, 18));
            if (v > 127) v = 127;
        end
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst           = 1'b0;
        bus.wr_en     = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.req_valid = 1'b0;
        bus.a_value   = '0;
        bus.rsp_ready = 1'b0;
        model_identity();

        #1;
        check_val("reset_req_ready", int'(bus.req_ready), 1);
        check_val("reset_rsp_valid", int'(bus.rsp_valid), 0);
        check_val("reset_z_value", int'(bus.z_value), 0);
        check_val("reset_rsp_clamp", int'(bus.rsp_clamp), 0);
        #11 rst = 1'b1;
        @(posedge clk); #1;

        // Identity table, interior point, held response.
        run_req(32, 5, 1'b0);
        // Lower end (normal path) and upper end (clamp path).
        run_req(-128, 0, 1'b0);
        run_req(127, 1, 1'b0);
        run_req(-100, 0, 1'b0);

        // Modified segment.
        tb_write(5, -40);
        run_req(-52, 0, 1'b0);
        check_val("seg_example_model_z", int'(bus.z_value), -56);

        // Out-of-range write address is ignored.
        tb_write(17, 5);
        run_req(-52, 0, 1'b0);

        // Write attempt during SEARCH is ignored.
        run_req(32, 0, 1'b1);
        run_req(32, 0, 1'b0);

        // Reset in the middle of DIVIDE.
        bus.req_valid = 1'b1;
        bus.a_value   = 8'sd0 - 8'sd52;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
        end
        #2 rst = 1'b0;
        #1;
        check_val("abort_rsp_valid", int'(bus.rsp_valid), 0);
        check_val("abort_req_ready", int'(bus.req_ready), 1);
        model_identity();
        @(posedge clk); #1;
        check_val("abort_no_rsp", int'(bus.rsp_valid), 0);
        #2 rst = 1'b1;
        @(posedge clk); #1;
        check_val("after_abort_no_rsp", int'(bus.rsp_valid), 0);
        run_req(-44, 0, 1'b0);

        // Randomized requests over random monotonic tables.
        for (int it = 0; it < 48; it++) begin
            int a;
            if (it % 12 == 0) random_table();
            if ($urandom_range(0, 3) == 0)
                a = int'($urandom_range(0, 255)) - 128;
            else
                a = mt[0] + int'($urandom_range(0, 32'(mt[16] - mt[0])));
            run_req(a, int'($urandom_range(0, 3)), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
